up_down_mod_counter: RTL and testbench
======================================

# up_down_mod_counter

Parametrised up/down modulo-N counter, the next generation of the team's 4-bit up/down counter. Counts over 0..N-1 with a run-time modulus, direction, enable, synchronous load and a selectable wrap or saturate mode, plus terminal-count and wrap-event outputs. Used as the generic loop/index counter in the datapath test designs.

## Interface
- WIDTH, 4: counter and modulus width in bits (≥ 2).
- clk  in  1  rising-edge clock.
- resetb  in  1  asynchronous, active-low reset.
- en  in  1  count enable; a step is taken only when high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sat  in  1  mode: 0 = wrap, 1 = saturate at the range ends.
- load  in  1  synchronous load of load_val; overrides en.
- load_val  in  WIDTH  value to load.
- N  in  WIDTH  modulus; legal range is 0..N-1; N = 0 means full range 2^WIDTH.
- count  out  WIDTH  registered count.
- tc  out  1  combinational: count is at the terminal value for the current direction (N-1 when up, 0 when down).
- wrap_evt  out  1  registered one-cycle pulse: the previous edge performed a wrap (never asserted in sat mode).

## Operation
- Define TOP = N-1 when N ≠ 0, else 2^WIDTH-1 (all ones). Width arithmetic is done in WIDTH+1 bits; no silent truncation.
- Priority per edge: resetb low > load > en > hold.
- load: count ← load_val if load_val ≤ TOP, else TOP. wrap_evt ← 0.
- en, up, count < TOP: count ← count+1.
- en, up, count = TOP: wrap mode → 0 with wrap_evt ← 1; sat mode → hold TOP.
- en, down, count > 0 and count ≤ TOP: count ← count-1.
- en, down, count = 0: wrap mode → TOP with wrap_evt ← 1; sat mode → hold 0.
- Out of range (count > TOP, after N is lowered at run time): with en, up → 0 (wrap, wrap_evt ← 1) or TOP (sat); down → TOP in both modes, wrap_evt ← 0. Without en, count holds out of range.
- en low and load low: count holds; wrap_evt ← 0.
- N = 1: TOP = 0; wrap mode pulses wrap_evt on every enabled step, count stays 0.

## Timing
- Reset: count = 0, wrap_evt = 0 immediately on resetb falling, independent of clk; tc then reflects count = 0 (1 when up = 0, or when up = 1 and TOP = 0).
- Release of resetb is synchronous in effect: first state change on the first rising edge with resetb high.
- count and wrap_evt change only on rising clk; one-cycle latency from en/load/up/N/sat to count.
- tc follows count, up and N combinationally in the same cycle; no registered delay.
- Changes to N, up or sat between edges take effect on the next edge; no glitch requirement on tc.

## Structure
- Shared package up_down_pkg: mode constants MODE_WRAP = 0, MODE_SAT = 1, and a function computing TOP from N and WIDTH.
- One sub-module is natural: up_down_mod_next, purely combinational, taking count, N, up, sat, en, load, load_val and returning next count and the wrap flag. The top holds only the count and wrap_evt registers and the tc decode.

## Test plan
- Reset: WIDTH = 4, drive resetb = 0 mid-count at count = 7 between edges → count = 0, wrap_evt = 0 without a clock edge.
- Wrap up: N = 10, up = 1, sat = 0, en = 1 from 0, 10 edges → 1..9 then 0; wrap_evt = 1 for exactly one cycle after 9→0; tc = 1 while count = 9.
- Saturate down: N = 10, up = 0, sat = 1, load 2 then 4 enabled edges → 1, 0, 0, 0; wrap_evt never asserted; tc = 1 at 0.
- Load clamp and priority: N = 8, load = 1, en = 1, load_val = 11 → count = 7; load_val = 3 → count = 3 (load wins over en).
- Run-time N change: count = 9 with N = 10, set N = 7; up wrap → 0 with wrap_evt = 1; repeat with down → 6, wrap_evt = 0.
- Full range: N = 0, up, wrap from 14 → 15 → 0 with wrap_evt; N = 1 wrap mode → count stays 0, wrap_evt = 1 every enabled cycle.

Source files
------------

// File: rtl/up_down_mod_counter_pkg.sv
// rtl/up_down_mod_counter_pkg.sv - shared constants and TOP helper for the up/down modulo-N counter
package up_down_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter supported; TOP is carried one bit wider so N = 0 never truncates.
    localparam int MAX_WIDTH = 31;

    localparam logic [MAX_WIDTH:0] ONE_EXT = {{MAX_WIDTH{1'b0}}, 1'b1};

    // TOP = N-1, or all ones of the counter width when N = 0 (full range).
    function automatic logic [MAX_WIDTH:0] calc_top(input logic [MAX_WIDTH:0] n_ext,
                                                    input int width);
        logic [MAX_WIDTH:0] ones;
        ones = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                ones[i] = 1'b1;
            end
        end
        if (n_ext == '0) begin
            return ones;
        end
        return n_ext - ONE_EXT;
    endfunction

endpackage

// File: rtl/up_down_mod_counter_if.sv
// rtl/up_down_mod_counter_if.sv - control and status bundle of the up/down modulo-N counter
interface up_down_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap_evt;

    modport master (
        output en, up, sat, load, load_val, N,
        input  count, tc, wrap_evt
    );

    modport slave (
        input  en, up, sat, load, load_val, N,
        output count, tc, wrap_evt
    );
endinterface

// File: rtl/up_down_mod_counter_next.sv
// rtl/up_down_mod_counter_next.sv - combinational next-count and wrap decision
module up_down_mod_next
    import up_down_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] n_i,
    input  logic             up_i,
    input  logic             sat_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] STEP = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [MAX_WIDTH:0] n_ext;
    logic [MAX_WIDTH:0] cnt_ext;
    logic [MAX_WIDTH:0] lv_ext;
    logic [MAX_WIDTH:0] top_ext;

    // All range comparisons are made on zero-extended values so TOP = 2^WIDTH-1 is exact.
    always_comb begin
        n_ext                  = '0;
        cnt_ext                = '0;
        lv_ext                 = '0;
        n_ext[WIDTH-1:0]       = n_i;
        cnt_ext[WIDTH-1:0]     = count_i;
        lv_ext[WIDTH-1:0]      = load_val_i;
        top_ext                = calc_top(n_ext, WIDTH);
    end

    always_comb begin
        count_o = count_i;
        wrap_o  = 1'b0;
        if (load_i) begin
            count_o = (lv_ext <= top_ext) ? load_val_i : top_ext[WIDTH-1:0];
        end else if (en_i) begin
            if (up_i) begin
                if (cnt_ext < top_ext) begin
                    count_o = count_i + STEP;
                end else if (sat_i == MODE_SAT) begin
                    count_o = top_ext[WIDTH-1:0];
                end else begin
                    // At TOP or above it (N lowered at run time): wrap to zero.
                    count_o = '0;
                    wrap_o  = 1'b1;
                end
            end else begin
                if (cnt_ext > top_ext) begin
                    count_o = top_ext[WIDTH-1:0];
                end else if (count_i == '0) begin
                    if (sat_i != MODE_SAT) begin
                        count_o = top_ext[WIDTH-1:0];
                        wrap_o  = 1'b1;
                    end
                end else begin
                    count_o = count_i - STEP;
                end
            end
        end
    end

endmodule

// File: rtl/up_down_mod_counter.sv
// rtl/up_down_mod_counter.sv - registered up/down modulo-N counter with terminal-count and wrap pulse
module up_down_mod_counter
    import up_down_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetb,
    up_down_mod_counter_if.slave bus
);

    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   count_d;
    logic               wrap_q;
    logic               wrap_d;
    logic [MAX_WIDTH:0] n_ext;
    logic [MAX_WIDTH:0] cnt_ext;
    logic [MAX_WIDTH:0] top_ext;
    logic               tc;

    up_down_mod_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count_i    (count_q),
        .n_i        (bus.N),
        .up_i       (bus.up),
        .sat_i      (bus.sat),
        .en_i       (bus.en),
        .load_i     (bus.load),
        .load_val_i (bus.load_val),
        .count_o    (count_d),
        .wrap_o     (wrap_d)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Terminal count is decoded straight from the live count, direction and modulus.
    always_comb begin
        n_ext              = '0;
        cnt_ext            = '0;
        n_ext[WIDTH-1:0]   = bus.N;
        cnt_ext[WIDTH-1:0] = count_q;
        top_ext            = calc_top(n_ext, WIDTH);
        if (bus.up) begin
            tc = (cnt_ext == top_ext);
        end else begin
            tc = (count_q == '0);
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap_evt = wrap_q;
    assign bus.tc       = tc;

endmodule

// File: tb/tb_up_down_mod_counter.sv
// tb/tb_up_down_mod_counter.sv - directed vector bench for up_down_mod_counter
module tb_up_down_mod_counter;

    logic clk;
    logic resetb;
    int   checks;
    int   failures;

    up_down_mod_counter_if #(.WIDTH(4)) bus ();

    up_down_mod_counter #(
        .WIDTH(4)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic       sat;
        logic [3:0] n;
        logic [3:0] exp_count;
        logic       exp_wrap;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic load, logic [3:0] lv, logic en, logic up,
                                logic sat, logic [3:0] n, logic [3:0] c, logic w, logic t);
        vec_t v;
        v.name = name; v.load = load; v.lv = lv; v.en = en; v.up = up; v.sat = sat;
        v.n = n; v.exp_count = c; v.exp_wrap = w; v.exp_tc = t;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [3:0] c, logic w, logic t);
        checks = checks + 3;
        if (bus.count !== c) begin
            failures = failures + 1;
            $display("FAIL %s count: got %0d want %0d", name, bus.count, c);
        end
        if (bus.wrap_evt !== w) begin
            failures = failures + 1;
            $display("FAIL %s wrap_evt: got %b want %b", name, bus.wrap_evt, w);
        end
        if (bus.tc !== t) begin
            failures = failures + 1;
            $display("FAIL %s tc: got %b want %b", name, bus.tc, t);
        end
    endtask

    task automatic step(logic load, logic [3:0] lv, logic en, logic up, logic sat, logic [3:0] n);
        @(negedge clk);
        bus.load = load; bus.load_val = lv; bus.en = en;
        bus.up = up; bus.sat = sat; bus.N = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // wrap up over 0..9
        for (int i = 1; i <= 9; i++)
            add("wrap_up", 0, 0, 1, 1, 0, 10, 4'(i), 0, (i == 9));
        add("wrap_up_9to0", 0, 0, 1, 1, 0, 10, 0, 1, 0);
        add("hold_after_wrap", 0, 0, 0, 1, 0, 10, 0, 0, 0);
        // saturate down from 2
        add("sat_load2", 1, 2, 0, 0, 1, 10, 2, 0, 0);
        add("sat_dn1", 0, 0, 1, 0, 1, 10, 1, 0, 0);
        add("sat_dn0", 0, 0, 1, 0, 1, 10, 0, 0, 1);
        add("sat_dn0b", 0, 0, 1, 0, 1, 10, 0, 0, 1);
        add("sat_dn0c", 0, 0, 1, 0, 1, 10, 0, 0, 1);
        // load clamp and load over en
        add("load_clamp", 1, 11, 1, 0, 0, 8, 7, 0, 0);
        add("load_prio", 1, 3, 1, 0, 0, 8, 3, 0, 0);
        // run-time N lowered below count
        add("rt_load9", 1, 9, 0, 1, 0, 10, 9, 0, 1);
        add("rt_up_oor", 0, 0, 1, 1, 0, 7, 0, 1, 0);
        add("rt_load9b", 1, 9, 0, 1, 0, 10, 9, 0, 1);
        add("rt_dn_oor", 0, 0, 1, 0, 0, 7, 6, 0, 0);
        add("rt_load9c", 1, 9, 0, 1, 0, 10, 9, 0, 1);
        add("rt_hold_oor", 0, 0, 0, 1, 0, 7, 9, 0, 0);
        add("rt_sat_up_oor", 0, 0, 1, 1, 1, 7, 6, 0, 1);
        add("sat_load9", 1, 9, 0, 1, 1, 10, 9, 0, 1);
        add("sat_up_top", 0, 0, 1, 1, 1, 10, 9, 0, 1);
        // full range N = 0
        add("full_load14", 1, 14, 0, 1, 0, 0, 14, 0, 0);
        add("full_up15", 0, 0, 1, 1, 0, 0, 15, 0, 1);
        add("full_wrap", 0, 0, 1, 1, 0, 0, 0, 1, 0);
        add("full_dn_wrap", 0, 0, 1, 0, 0, 0, 15, 1, 0);
        // N = 1
        add("n1_load", 1, 0, 0, 1, 0, 1, 0, 0, 1);
        add("n1_up_a", 0, 0, 1, 1, 0, 1, 0, 1, 1);
        add("n1_up_b", 0, 0, 1, 1, 0, 1, 0, 1, 1);
        add("n1_dn", 0, 0, 1, 0, 0, 1, 0, 1, 1);
        add("n1_idle", 0, 0, 0, 0, 0, 1, 0, 0, 1);

        bus.load = 0; bus.load_val = 0; bus.en = 0;
        bus.up = 0; bus.sat = 0; bus.N = 4'd10;
        resetb = 1'b0;
        #12;
        check("reset", 0, 0, 1);
        @(negedge clk);
        resetb = 1'b1;

        foreach (vecs[i])
        begin
            step(vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].n);
            check(vecs[i].name, vecs[i].exp_count, vecs[i].exp_wrap, vecs[i].exp_tc);
        end

        // async reset mid-count at 7, between edges
        step(1, 5, 0, 1, 0, 10);
        step(0, 0, 1, 1, 0, 10);
        step(0, 0, 1, 1, 0, 10);
        check("pre_reset7", 7, 0, 0);
        #2 resetb = 1'b0;
        #1;
        check("async_reset", 0, 0, 0);
        @(posedge clk);
        #1;
        check("reset_held", 0, 0, 0);
        @(negedge clk);
        resetb = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_after_release", 1, 0, 0);

        // async reset clears a pending wrap pulse
        step(1, 0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 0, 1);
        check("n1_pulse", 0, 1, 1);
        #2 resetb = 1'b0;
        #1;
        check("reset_clears_wrap", 0, 0, 1);
        @(negedge clk);
        resetb = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
